dds_sweep_master: RTL and testbench
===================================

# dds_sweep_master

Bus master that drives linear frequency sweeps on the DDS slave. Configuration is latched on a start pulse. The block writes successive frequency words into one channel/store `freq_ctrl` register through single-beat write bursts, and holds each word for a programmable dwell time. It sits on the interconnect beside the host master, targets the DDS slave window, and replaces host-timed register pokes with cycle-exact sweeps.

## Interface
Parameters:
- OFFSET_ADDR, 32'h4000_0000, base address of the DDS slave window
- CHANNEL_NUM, 2, number of DDS channels; a larger `cfg_channel` is rejected
- MASTER_ID, 4'h0, ID driven on every write address beat

Ports (clock is `clk`; reset is `rstn`, asynchronous, active-low):
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- stop  in  1  level or pulse; requests sweep end
- cfg_channel  in  4  target channel
- cfg_store  in  2  target store index 0..3
- cfg_f_start  in  32  first frequency word
- cfg_f_step  in  32  increment, unsigned
- cfg_f_stop  in  32  last allowed frequency word, inclusive
- cfg_dwell  in  32  hold cycles after each write response
- cfg_loop  in  1  1 = restart at f_start after passing f_stop
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on return to IDLE
- err  out  1  sticky; cleared by the next accepted start
- cur_freq  out  32  frequency word of the current or last write
- SWEEP_MASTER_WR_ADDR_ID  out  4  = MASTER_ID
- SWEEP_MASTER_WR_ADDR  out  32  target address
- SWEEP_MASTER_WR_ADDR_LEN  out  8  constant 0
- SWEEP_MASTER_WR_ADDR_BURST  out  2  constant 2'b01
- SWEEP_MASTER_WR_ADDR_VALID  out  1
- SWEEP_MASTER_WR_ADDR_READY  in  1
- SWEEP_MASTER_WR_DATA  out  32  = cur_freq
- SWEEP_MASTER_WR_STRB  out  4  constant 4'hF
- SWEEP_MASTER_WR_DATA_LAST  out  1  = WR_DATA_VALID
- SWEEP_MASTER_WR_DATA_VALID  out  1
- SWEEP_MASTER_WR_DATA_READY  in  1
- SWEEP_MASTER_WR_BACK_ID  in  4  ignored
- SWEEP_MASTER_WR_BACK_RESP  in  2  2'b00 = OK; anything else = error
- SWEEP_MASTER_WR_BACK_VALID  in  1
- SWEEP_MASTER_WR_BACK_READY  out  1

## Operation
- States: IDLE, ADDR, DATA, RESP, DWELL. Every valid/ready pair is a handshake; a beat transfers when both are high in the same cycle.
- IDLE + start:
  - Latch all cfg_* inputs.
  - Set cur_freq = f_start; clear err.
  - If cfg_channel >= CHANNEL_NUM, or f_start > f_stop: set err, pulse done, stay IDLE.
  - Otherwise go to ADDR.
- Address formula: WR_ADDR = OFFSET_ADDR + {24'b0, channel, 4'h1 + store}.
- ADDR: WR_ADDR_VALID high until its handshake, then go to DATA.
- DATA: WR_DATA_VALID and LAST high until handshake, then go to RESP.
- RESP: BACK_READY high.
  - On BACK_VALID with RESP != 0: set err, pulse done, go to IDLE.
  - On BACK_VALID with RESP = 0: load the dwell counter with cfg_dwell, go to DWELL.
- DWELL: decrement the counter each cycle; leave when it reads 0 (cfg_dwell = 0 means zero wait cycles).
  - Compute next = cur_freq + f_step as a 33-bit sum.
  - If stop is pending: done, IDLE.
  - Else if next[32] = 1 or next[31:0] > f_stop: if cfg_loop, cur_freq = f_start and go to ADDR; else done, IDLE.
  - Else cur_freq = next[31:0], go to ADDR.
- stop handling: stop seen in any non-IDLE state sets a pending flag. An in-flight transaction always completes through RESP before the block goes idle. The flag is honoured in DWELL, immediately, without waiting out the counter. The flag clears in IDLE.
- f_step = 0: the same word is rewritten every dwell period until stop.

## Timing
- Reset values:
  - All VALID/READY outputs and busy, done, err are 0.
  - cur_freq = 0; state = IDLE.
  - ADDR = OFFSET_ADDR + 1.
  - ID, LEN, BURST, STRB, DATA = constants or reset register values.
- All bus outputs are registered or decoded directly from state; none depend combinationally on READY inputs.
- The cycle after start is accepted, WR_ADDR_VALID = 1.
- Minimum write-to-write spacing with all READYs tied high: 4 + cfg_dwell cycles (ADDR, DATA, RESP, DWELL exit cycle, plus dwell).
- A VALID never drops before its handshake; ADDR and DATA are stable while VALID is high.
- done is high for exactly 1 cycle, in the first IDLE cycle.
- Asynchronous reset mid-transaction drops all VALIDs immediately. Bus recovery is the interconnect's concern.

## Structure
- Shared package `dds_pkg`:
  - state enum
  - register offsets FREQ_BASE = 4'h1, PHASE_BASE = 4'h5, WR_EN = 4'h9, DATA = 4'hA
  - BURST_INCR = 2'b01, RESP_OKAY = 2'b00
- Single module; no sub-module. The write-channel FSM is small, and the dwell counter is inline.

## Test plan
- Basic sweep: f_start=100, step=50, stop=250, dwell=3, channel 1, store 2, loop=0 -> writes 100, 150, 200, 250 to OFFSET_ADDR+0x13; done pulse; err=0.
- Backpressure: random ADDR_READY/DATA_READY/BACK_VALID stalls -> data and address held stable, same write sequence as the basic sweep.
- Overflow: f_start=32'hFFFF_FFF0, step=32'h20, stop=32'hFFFF_FFFF, loop=1 -> writes FFFF_FFF0, FFFF_FFF0, ... (wraps to f_start, never 0x10).
- Stop: stop pulse during DATA of the second write -> that write completes, no third write, done within dwell+2 cycles.
- Error: BACK_RESP=2'b10 on the first write -> err=1, done pulse, busy=0; cfg_channel=2 with CHANNEL_NUM=2 -> err with zero bus activity.
- Reset: rstn low during DWELL -> all outputs return to their reset values in the same cycle.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep master and its slave register map.
package dds_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_DATA  = 3'd2,
      ST_RESP  = 3'd3,
      ST_DWELL = 3'd4
   } sweep_state_e;

   // Register offsets inside one DDS channel page
   localparam logic [3:0] FREQ_BASE  = 4'h1;
   localparam logic [3:0] PHASE_BASE = 4'h5;
   localparam logic [3:0] WR_EN      = 4'h9;
   localparam logic [3:0] DATA       = 4'hA;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/dds_sweep_master.sv
// Linear frequency sweep master: writes successive frequency words to one
// DDS channel/store freq register, holding each for a programmable dwell.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; config latched and checked on start
// ST_ADDR  | write address beat offered
// ST_DATA  | write data beat offered (single beat, LAST tied to VALID)
// ST_RESP  | waiting for write response
// ST_DWELL | hold current word; next word / loop / end decided on exit
module dds_sweep_master
   import dds_pkg::*;
#(
   parameter logic [31:0] OFFSET_ADDR = 32'h4000_0000,
   parameter int          CHANNEL_NUM = 2,
   parameter logic [3:0]  MASTER_ID   = 4'h0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic        stop,
   input  logic [3:0]  cfg_channel,
   input  logic [1:0]  cfg_store,
   input  logic [31:0] cfg_f_start,
   input  logic [31:0] cfg_f_step,
   input  logic [31:0] cfg_f_stop,
   input  logic [31:0] cfg_dwell,
   input  logic        cfg_loop,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] cur_freq,
   output logic [3:0]  SWEEP_MASTER_WR_ADDR_ID,
   output logic [31:0] SWEEP_MASTER_WR_ADDR,
   output logic [7:0]  SWEEP_MASTER_WR_ADDR_LEN,
   output logic [1:0]  SWEEP_MASTER_WR_ADDR_BURST,
   output logic        SWEEP_MASTER_WR_ADDR_VALID,
   input  logic        SWEEP_MASTER_WR_ADDR_READY,
   output logic [31:0] SWEEP_MASTER_WR_DATA,
   output logic [3:0]  SWEEP_MASTER_WR_STRB,
   output logic        SWEEP_MASTER_WR_DATA_LAST,
   output logic        SWEEP_MASTER_WR_DATA_VALID,
   input  logic        SWEEP_MASTER_WR_DATA_READY,
   input  logic [3:0]  SWEEP_MASTER_WR_BACK_ID,
   input  logic [1:0]  SWEEP_MASTER_WR_BACK_RESP,
   input  logic        SWEEP_MASTER_WR_BACK_VALID,
   output logic        SWEEP_MASTER_WR_BACK_READY
);

   localparam logic [31:0] CH_LIMIT = 32'(CHANNEL_NUM);

   sweep_state_e state_q, state_d;
   logic [3:0]   chan_q;
   logic [1:0]   store_q;
   logic [31:0]  f_start_q, f_step_q, f_stop_q, dwell_q;
   logic         loop_q;
   logic [31:0]  cur_freq_q, cur_freq_d;
   logic [31:0]  dwell_cnt_q, dwell_cnt_d;
   logic         err_q, err_d;
   logic         done_q, done_d;
   logic         stop_pend_q, stop_pend_d;
   logic         cfg_latch;
   logic [32:0]  next_sum;
   logic         unused_back_id;

   // Response ID carries no information for a single outstanding write
   assign unused_back_id = ^SWEEP_MASTER_WR_BACK_ID;

   assign next_sum = {1'b0, cur_freq_q} + {1'b0, f_step_q};

   // Next-state, datapath updates and stop bookkeeping
   always_comb begin
      state_d     = state_q;
      cur_freq_d  = cur_freq_q;
      dwell_cnt_d = dwell_cnt_q;
      err_d       = err_q;
      done_d      = 1'b0;
      cfg_latch   = 1'b0;
      stop_pend_d = stop_pend_q | (stop && (state_q != ST_IDLE));
      case (state_q)
         ST_IDLE: begin
            stop_pend_d = 1'b0;
            if (start) begin
               cfg_latch  = 1'b1;
               cur_freq_d = cfg_f_start;
               err_d      = 1'b0;
               if (({28'b0, cfg_channel} >= CH_LIMIT) || (cfg_f_start > cfg_f_stop)) begin
                  err_d  = 1'b1;
                  done_d = 1'b1;
               end else begin
                  state_d = ST_ADDR;
               end
            end
         end
         ST_ADDR: begin
            if (SWEEP_MASTER_WR_ADDR_READY) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (SWEEP_MASTER_WR_DATA_READY) state_d = ST_RESP;
         end
         ST_RESP: begin
            if (SWEEP_MASTER_WR_BACK_VALID) begin
               if (SWEEP_MASTER_WR_BACK_RESP != RESP_OKAY) begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  dwell_cnt_d = dwell_q;
                  state_d     = ST_DWELL;
               end
            end
         end
         ST_DWELL: begin
            // A pending stop cuts the dwell short; no further write is issued
            if (stop_pend_d) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else if (dwell_cnt_q == 32'd0) begin
               if (next_sum[32] || (next_sum[31:0] > f_stop_q)) begin
                  if (loop_q) begin
                     cur_freq_d = f_start_q;
                     state_d    = ST_ADDR;
                  end else begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               end else begin
                  cur_freq_d = next_sum[31:0];
                  state_d    = ST_ADDR;
               end
            end else begin
               dwell_cnt_d = dwell_cnt_q - 32'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state and sweep status registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         cur_freq_q  <= 32'd0;
         dwell_cnt_q <= 32'd0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_freq_q  <= cur_freq_d;
         dwell_cnt_q <= dwell_cnt_d;
         err_q       <= err_d;
         done_q      <= done_d;
         stop_pend_q <= stop_pend_d;
      end
   end

   // Sweep configuration captured on an accepted start
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         chan_q    <= 4'd0;
         store_q   <= 2'd0;
         f_start_q <= 32'd0;
         f_step_q  <= 32'd0;
         f_stop_q  <= 32'd0;
         dwell_q   <= 32'd0;
         loop_q    <= 1'b0;
      end else if (cfg_latch) begin
         chan_q    <= cfg_channel;
         store_q   <= cfg_store;
         f_start_q <= cfg_f_start;
         f_step_q  <= cfg_f_step;
         f_stop_q  <= cfg_f_stop;
         dwell_q   <= cfg_dwell;
         loop_q    <= cfg_loop;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign err      = err_q;
   assign cur_freq = cur_freq_q;

   assign SWEEP_MASTER_WR_ADDR_ID    = MASTER_ID;
   assign SWEEP_MASTER_WR_ADDR       = OFFSET_ADDR + {24'b0, chan_q, FREQ_BASE + {2'b00, store_q}};
   assign SWEEP_MASTER_WR_ADDR_LEN   = 8'd0;
   assign SWEEP_MASTER_WR_ADDR_BURST = BURST_INCR;
   assign SWEEP_MASTER_WR_ADDR_VALID = (state_q == ST_ADDR);
   assign SWEEP_MASTER_WR_DATA       = cur_freq_q;
   assign SWEEP_MASTER_WR_STRB       = 4'hF;
   assign SWEEP_MASTER_WR_DATA_VALID = (state_q == ST_DATA);
   assign SWEEP_MASTER_WR_DATA_LAST  = (state_q == ST_DATA);
   assign SWEEP_MASTER_WR_BACK_READY = (state_q == ST_RESP);

endmodule

// File: tb/tb_dds_sweep_master.sv
// Directed + randomized bench for dds_sweep_master with a list-based sweep model.
module tb_dds_sweep_master;

   localparam logic [31:0] OFFS = 32'h4000_0000;
   localparam int          NCH  = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0, stop = 1'b0;
   logic [3:0]  cfg_channel = '0;
   logic [1:0]  cfg_store = '0;
   logic [31:0] cfg_f_start = '0, cfg_f_step = '0, cfg_f_stop = '0, cfg_dwell = '0;
   logic        cfg_loop = 1'b0;
   logic        busy, done, err;
   logic [31:0] cur_freq;
   logic [3:0]  aw_id;
   logic [31:0] aw_addr;
   logic [7:0]  aw_len;
   logic [1:0]  aw_burst;
   logic        aw_valid, aw_ready = 1'b0;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        w_last, w_valid, w_ready = 1'b0;
   logic [3:0]  b_id = 4'h3;
   logic [1:0]  b_resp = 2'b00;
   logic        b_valid = 1'b0, b_ready;

   dds_sweep_master dut (
      .clk(clk), .rstn(rstn), .start(start), .stop(stop),
      .cfg_channel(cfg_channel), .cfg_store(cfg_store), .cfg_f_start(cfg_f_start),
      .cfg_f_step(cfg_f_step), .cfg_f_stop(cfg_f_stop), .cfg_dwell(cfg_dwell),
      .cfg_loop(cfg_loop), .busy(busy), .done(done), .err(err), .cur_freq(cur_freq),
      .SWEEP_MASTER_WR_ADDR_ID(aw_id), .SWEEP_MASTER_WR_ADDR(aw_addr),
      .SWEEP_MASTER_WR_ADDR_LEN(aw_len), .SWEEP_MASTER_WR_ADDR_BURST(aw_burst),
      .SWEEP_MASTER_WR_ADDR_VALID(aw_valid), .SWEEP_MASTER_WR_ADDR_READY(aw_ready),
      .SWEEP_MASTER_WR_DATA(w_data), .SWEEP_MASTER_WR_STRB(w_strb),
      .SWEEP_MASTER_WR_DATA_LAST(w_last), .SWEEP_MASTER_WR_DATA_VALID(w_valid),
      .SWEEP_MASTER_WR_DATA_READY(w_ready), .SWEEP_MASTER_WR_BACK_ID(b_id),
      .SWEEP_MASTER_WR_BACK_RESP(b_resp), .SWEEP_MASTER_WR_BACK_VALID(b_valid),
      .SWEEP_MASTER_WR_BACK_READY(b_ready)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_freq[$];
   logic [31:0] exp_addr;
   logic [31:0] cur_dwell;
   bit          stall, stop_sent;
   int          cyc = 0;
   int          n_addr, n_data, n_resp, n_done, pending;
   int          stop_k, err_k, last_addr_cyc, resp_cyc;
   bit          prev_av, prev_ahs, prev_dv, prev_dhs;
   logic [31:0] prev_addr, prev_data;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One cycle at a negedge: check, pick handshake inputs, then advance.
   task automatic tick();
      bit ar, wr, bv, ahs, dhs, bhs;
      if (prev_av && !prev_ahs) begin
         chk("addr_valid_hold", aw_valid, 1);
         chk("addr_stable", aw_addr, prev_addr);
      end
      if (prev_dv && !prev_dhs) begin
         chk("data_valid_hold", w_valid, 1);
         chk("data_stable", w_data, prev_data);
      end
      if (done) begin
         n_done++;
         if (stop_sent) chk("stop_done_latency", (cyc - resp_cyc) <= int'(cur_dwell) + 2, 1);
      end
      ar = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      ahs = aw_valid && ar;
      dhs = w_valid && wr;
      if (ahs) begin
         chk("wr_addr", aw_addr, exp_addr);
         chk("wr_len", aw_len, 0);
         chk("wr_burst", aw_burst, 1);
         chk("wr_id", aw_id, 0);
         if (!stall && n_addr > 0) chk("write_spacing", cyc - last_addr_cyc, 4 + cur_dwell);
         last_addr_cyc = cyc;
         n_addr++;
      end
      if (dhs) begin
         if (n_data < exp_freq.size()) chk("wr_data", w_data, exp_freq[n_data]);
         else chk("no_extra_write", n_data, exp_freq.size());
         chk("wr_last", w_last, 1);
         chk("wr_strb", w_strb, 4'hF);
         n_data++;
         pending++;
      end
      bv = (pending > 0) && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
      b_resp = (err_k > 0 && n_resp + 1 == err_k) ? 2'b10 : 2'b00;
      bhs = b_ready && bv;
      if (bhs) begin
         n_resp++;
         pending--;
         resp_cyc = cyc;
      end
      stop = dhs && stop_k > 0 && n_data == stop_k;
      if (stop) stop_sent = 1;
      aw_ready = ar;
      w_ready  = wr;
      b_valid  = bv;
      prev_av = aw_valid; prev_ahs = ahs; prev_addr = aw_addr;
      prev_dv = w_valid;  prev_dhs = dhs; prev_data = w_data;
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_sweep(input bit stl, input logic [3:0] ch, input logic [1:0] st,
                            input logic [31:0] fs, input logic [31:0] step,
                            input logic [31:0] fe, input logic [31:0] dw,
                            input bit lp, input int sk, input int ek);
      bit ok_cfg;
      logic [63:0] f;
      int budget;
      ok_cfg = (int'(ch) < NCH) && (fs <= fe);
      exp_freq.delete();
      if (ok_cfg) begin
         f = {32'b0, fs};
         while (exp_freq.size() < 100) begin
            if (f > {32'b0, fe}) begin
               if (lp) f = {32'b0, fs};
               else break;
            end
            exp_freq.push_back(f[31:0]);
            f = f + {32'b0, step};
         end
         if (sk > 0) while (exp_freq.size() > sk) void'(exp_freq.pop_back());
         if (ek > 0) while (exp_freq.size() > ek) void'(exp_freq.pop_back());
      end
      exp_addr = OFFS + 32'(ch) * 32'd16 + 32'd1 + 32'(st);
      stall = stl; stop_k = sk; err_k = ek; cur_dwell = dw; stop_sent = 0;
      n_addr = 0; n_data = 0; n_resp = 0; n_done = 0; pending = 0;
      prev_av = 0; prev_dv = 0; prev_ahs = 0; prev_dhs = 0;
      cfg_channel = ch; cfg_store = st; cfg_f_start = fs; cfg_f_step = step;
      cfg_f_stop = fe; cfg_dwell = dw; cfg_loop = lp;
      start = 1;
      @(negedge clk);
      cyc++;
      start = 0;
      chk("addr_valid_after_start", aw_valid, ok_cfg);
      chk("busy_after_start", busy, ok_cfg);
      chk("err_after_start", err, !ok_cfg);
      budget = cyc + 5000;
      while (n_done == 0 && cyc < budget) tick();
      chk("sweep_timeout", cyc < budget, 1);
      chk("done_single_cycle", done, 0);
      chk("done_count", n_done, 1);
      chk("busy_end", busy, 0);
      chk("err_end", err, (!ok_cfg) || (ek > 0));
      chk("write_count", n_data, exp_freq.size());
      chk("addr_count", n_addr, exp_freq.size());
      chk("resp_count", n_resp, n_data);
      chk("cur_freq_end", cur_freq, (exp_freq.size() > 0) ? exp_freq[exp_freq.size() - 1] : fs);
      stop = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
      if (cyc >= budget) begin
         rstn = 0;
         @(negedge clk);
         rstn = 1;
      end
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      bit found;
      rstn = 0;
      repeat (3) @(negedge clk);
      chk("rst_aw_valid", aw_valid, 0);
      chk("rst_w_valid", w_valid, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_cur_freq", cur_freq, 0);
      chk("rst_addr", aw_addr, OFFS + 32'd1);
      chk("rst_data", w_data, 0);
      rstn = 1;
      @(negedge clk);

      run_sweep(0, 4'd1, 2'd2, 32'd100, 32'd50, 32'd250, 32'd3, 0, 0, 0);
      run_sweep(1, 4'd1, 2'd2, 32'd100, 32'd50, 32'd250, 32'd3, 0, 0, 0);
      run_sweep(1, 4'd0, 2'd0, 32'hFFFF_FFF0, 32'h20, 32'hFFFF_FFFF, 32'd2, 1, 4, 0);
      run_sweep(0, 4'd0, 2'd3, 32'hFFFF_FFF0, 32'h20, 32'hFFFF_FFFF, 32'd0, 1, 3, 0);
      run_sweep(0, 4'd1, 2'd2, 32'd100, 32'd50, 32'd250, 32'd3, 0, 2, 0);
      run_sweep(0, 4'd1, 2'd0, 32'd100, 32'd50, 32'd250, 32'd3, 0, 0, 1);
      run_sweep(0, 4'd0, 2'd3, 32'd7, 32'd1, 32'd9, 32'd1, 0, 0, 0);
      run_sweep(0, 4'd2, 2'd0, 32'd100, 32'd50, 32'd250, 32'd3, 0, 0, 0);
      run_sweep(0, 4'd1, 2'd1, 32'd500, 32'd50, 32'd400, 32'd3, 0, 0, 0);
      run_sweep(1, 4'd0, 2'd1, 32'd77, 32'd0, 32'd77, 32'd1, 0, 3, 0);
      run_sweep(0, 4'd1, 2'd1, 32'd10, 32'd5, 32'd30, 32'd0, 0, 0, 0);

      for (int i = 0; i < 6; i++) begin
         logic [31:0] fs, stp, fe, dw;
         bit lp;
         int sk;
         fs  = 32'($urandom_range(0, 1000));
         stp = 32'($urandom_range(20, 300));
         fe  = fs + 32'($urandom_range(0, 800));
         dw  = 32'($urandom_range(0, 4));
         lp  = 1'($urandom_range(0, 1));
         sk  = lp ? int'($urandom_range(1, 5)) : (($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0);
         run_sweep(1'($urandom_range(0, 1)), 4'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   fs, stp, fe, dw, lp, sk, 0);
      end

      // Asynchronous reset while dwelling
      cfg_channel = 4'd1; cfg_store = 2'd2; cfg_f_start = 32'd100; cfg_f_step = 32'd50;
      cfg_f_stop = 32'd250; cfg_dwell = 32'd3; cfg_loop = 0;
      start = 1;
      @(negedge clk);
      start = 0;
      aw_ready = 1; w_ready = 1; b_valid = 1; b_resp = 2'b00;
      found = 0;
      for (int k = 0; k < 50 && !found; k++) begin
         @(negedge clk);
         if (busy && !aw_valid && !w_valid && !b_ready) found = 1;
      end
      chk("reached_dwell", found, 1);
      #2 rstn = 0;
      #1;
      chk("arst_aw_valid", aw_valid, 0);
      chk("arst_w_valid", w_valid, 0);
      chk("arst_b_ready", b_ready, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_err", err, 0);
      chk("arst_cur_freq", cur_freq, 0);
      chk("arst_addr", aw_addr, OFFS + 32'd1);
      chk("arst_data", w_data, 0);
      aw_ready = 0; w_ready = 0; b_valid = 0;
      @(negedge clk);
      rstn = 1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
